// File: rtl/gshare_predictor_n.sv
// N-lane gshare predictor: shared 2-bit PHT indexed by PC^history, speculative GHR, EX-side repair/training.
// Optional macro GSHARE_UPD_BYPASS_EN: same-cycle training result is forwarded to fetch lanes.
module gshare_predictor_n #(
  parameter int LANES    = 2,
  parameter int PC_BITS  = 14,
  parameter int IDX_BITS = 10,
  parameter int GHR_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_F,
  input  logic [LANES-1:0]            fetch_branch,
  input  logic [LANES*PC_BITS-1:0]    fetch_pc,
  output logic [LANES-1:0]            pred_taken,
  output logic [LANES*GHR_BITS-1:0]   pred_ghr,
  input  logic                        upd_valid,
  input  logic [PC_BITS-1:0]          upd_pc,
  input  logic [GHR_BITS-1:0]         upd_ghr,
  input  logic                        upd_taken,
  input  logic                        upd_mispredict,
  output logic [GHR_BITS-1:0]         ghr_out
);

  localparam int PHT_DEPTH = 2 ** IDX_BITS;

  logic [1:0]          pht [PHT_DEPTH];
  logic [GHR_BITS-1:0] ghr;
  logic [GHR_BITS-1:0] h [LANES+1];
  logic [IDX_BITS-1:0] upd_idx;
  logic [1:0]          upd_ctr;
  logic                repair;
  logic                unused_pc;

  // Written via a wider concat so GHR_BITS=1 degenerates cleanly to "newest outcome".
  function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] hist,
                                                   input logic bit_in);
    logic [GHR_BITS:0] w;
    w = {hist, bit_in};
    return w[GHR_BITS-1:0];
  endfunction

  assign unused_pc = ^{fetch_pc, upd_pc};
  assign repair    = upd_valid & upd_mispredict;
  assign upd_idx   = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_ghr);
  assign ghr_out   = ghr;

  always_comb begin
    upd_ctr = pht[upd_idx];
    if (upd_taken) begin
      if (upd_ctr != 2'b11) upd_ctr = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) upd_ctr = upd_ctr - 2'b01;
    end
  end

  always_comb begin
    logic                taken_seen;
    logic [IDX_BITS-1:0] idx;
    logic [1:0]          ctr;
    logic                p;
    pred_taken = '0;
    pred_ghr   = '0;
    taken_seen = 1'b0;
    idx        = '0;
    ctr        = '0;
    p          = 1'b0;
    h[0]       = ghr;
    for (int i = 0; i < LANES; i++) begin
      idx = fetch_pc[i*PC_BITS+2 +: IDX_BITS] ^ IDX_BITS'(h[i]);
`ifdef GSHARE_UPD_BYPASS_EN
      ctr = (upd_valid && (idx == upd_idx)) ? upd_ctr : pht[idx];
`else
      ctr = pht[idx];
`endif
      p = fetch_branch[i] & ctr[1] & ~taken_seen;
      pred_taken[i] = p;
      pred_ghr[i*GHR_BITS +: GHR_BITS] = h[i];
      // Lanes behind a predicted-taken branch are dropped, so they never enter history.
      h[i+1] = (fetch_branch[i] && !taken_seen) ? shift_in(h[i], p) : h[i];
      taken_seen = taken_seen | p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
    end else begin
      if (repair)        ghr <= shift_in(upd_ghr, upd_taken);
      else if (!stall_F) ghr <= h[LANES];
      if (upd_valid) pht[upd_idx] <= upd_ctr;
    end
  end

endmodule

// File: tb/tb_gshare_predictor_n.sv
// Directed-vector scoreboard bench for gshare_predictor_n (default 2-lane build, either bypass setting).
module tb_gshare_predictor_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_F;
  logic [1:0]  fetch_branch;
  logic [27:0] fetch_pc;
  logic [1:0]  pred_taken;
  logic [15:0] pred_ghr;
  logic        upd_valid;
  logic [13:0] upd_pc;
  logic [7:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [7:0]  ghr_out;

`ifdef GSHARE_UPD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       chk_pred;
    logic [1:0] pred;
    logic [7:0] g0;
    logic [7:0] g1;
    logic [7:0] ghr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  gshare_predictor_n dut (
    .clk(clk), .rst(rst), .stall_F(stall_F),
    .fetch_branch(fetch_branch), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .ghr_out(ghr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs are valid mid-cycle, after the stimulus settled on the preceding rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".ghr_out"}, ghr_out, e.ghr);
        if (e.chk_pred) begin
          chk({e.name, ".pred_taken"}, {6'b0, pred_taken}, {6'b0, e.pred});
          chk({e.name, ".pred_ghr0"}, pred_ghr[7:0], e.g0);
          chk({e.name, ".pred_ghr1"}, pred_ghr[15:8], e.g1);
        end
      end
    end
  end

  task automatic step(input string name, input logic r, input logic st,
                      input logic [1:0] fb, input logic [13:0] pc0, input logic [13:0] pc1,
                      input logic uv, input logic [13:0] upc, input logic [7:0] ug,
                      input logic ut, input logic um,
                      input logic cp, input logic [1:0] ep, input logic [7:0] eg0,
                      input logic [7:0] eg1, input logic [7:0] eghr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall_F = st; fetch_branch = fb; fetch_pc = {pc1, pc0};
    upd_valid = uv; upd_pc = upc; upd_ghr = ug; upd_taken = ut; upd_mispredict = um;
    e.name = name; e.chk_pred = cp; e.pred = ep; e.g0 = eg0; e.g1 = eg1; e.ghr = eghr;
    q.push_back(e);
  endtask

  initial begin
    int budget;
    rst = 1'b1; stall_F = 1'b0; fetch_branch = '0; fetch_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    @(posedge clk);
    @(posedge clk);
    //      name        rst st  fb     pc0      pc1      uv  upc      ug     ut  um  cp  pred   g0     g1     ghr_out
    step("reset_fetch", 0, 0, 2'b01, 14'h0040, 14'h0000, 0, 14'h0000, 8'h00, 0, 0, 1, 2'b00, 8'h00, 8'h00, 8'h00);
    step("train1",      0, 0, 2'b00, 14'h0000, 14'h0000, 1, 14'h0040, 8'h00, 1, 0, 1, 2'b00, 8'h00, 8'h00, 8'h00);
    step("train2",      0, 0, 2'b00, 14'h0000, 14'h0000, 1, 14'h0040, 8'h00, 1, 0, 1, 2'b00, 8'h00, 8'h00, 8'h00);
    step("group_cut",   0, 0, 2'b11, 14'h0040, 14'h0080, 0, 14'h0000, 8'h00, 0, 0, 1, 2'b01, 8'h00, 8'h01, 8'h00);
    step("repair_a5",   0, 0, 2'b01, 14'h0040, 14'h0000, 1, 14'h0100, 8'h52, 1, 1, 1, 2'b00, 8'h01, 8'h02, 8'h01);
    step("repair_3c",   0, 0, 2'b01, 14'h0000, 14'h0000, 1, 14'h0000, 8'h3C, 0, 1, 1, 2'b00, 8'hA5, 8'h4A, 8'hA5);
    step("stall_sat3",  0, 1, 2'b11, 14'h0040, 14'h0080, 1, 14'h0040, 8'h00, 1, 0, 1, 2'b00, 8'h78, 8'hF0, 8'h78);
    step("stall_sat0",  0, 1, 2'b00, 14'h0000, 14'h0000, 1, 14'h0000, 8'h3C, 0, 0, 1, 2'b00, 8'h78, 8'h78, 8'h78);
    step("read_sat0",   0, 0, 2'b01, 14'h0110, 14'h0000, 1, 14'h3FFC, 8'h00, 0, 1, 1, 2'b00, 8'h78, 8'hF0, 8'h78);
    step("read_sat3",   0, 1, 2'b01, 14'h0040, 14'h0000, 0, 14'h0000, 8'h00, 0, 0, 1, 2'b01, 8'h00, 8'h01, 8'h00);
    step("bypass",      0, 1, 2'b01, 14'h0080, 14'h0000, 1, 14'h0080, 8'h00, 1, 0, 1, {1'b0, BYP}, 8'h00, {7'b0, BYP}, 8'h00);
    step("after_byp",   0, 0, 2'b01, 14'h0080, 14'h0000, 0, 14'h0000, 8'h00, 0, 0, 1, 2'b01, 8'h00, 8'h01, 8'h00);
    step("mp_novalid",  0, 0, 2'b10, 14'h0000, 14'h0040, 0, 14'h0000, 8'h3C, 1, 1, 1, 2'b00, 8'h01, 8'h01, 8'h01);
    step("mid_reset",   1, 0, 2'b01, 14'h0040, 14'h0000, 1, 14'h0040, 8'h00, 0, 1, 0, 2'b00, 8'h00, 8'h00, 8'h02);
    step("post_reset",  0, 0, 2'b01, 14'h0040, 14'h0000, 0, 14'h0000, 8'h00, 0, 0, 1, 2'b00, 8'h00, 8'h00, 8'h00);
    step("stale_upd",   0, 0, 2'b00, 14'h0000, 14'h0000, 1, 14'h0040, 8'hA5, 1, 1, 1, 2'b00, 8'h00, 8'h00, 8'h00);
    step("final",       0, 0, 2'b00, 14'h0000, 14'h0000, 0, 14'h0000, 8'h00, 0, 0, 1, 2'b00, 8'h4B, 8'h4B, 8'h4B);
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gshare_predictor_n.md
Name: gshare_predictor_n

Overview:
- Parametrised N-lane gshare conditional-branch predictor for the fetch stage of the superscalar core.
- Predicts up to LANES branches per fetch group from a shared PHT indexed by PC XOR global history.
- Updates the global history speculatively at fetch.
- Trains 2-bit counters and repairs history from resolved branches in EX.

Parameters:
LANES, 2, fetch lanes predicted per cycle (1..4)
PC_BITS, 14, PC bits presented per lane
IDX_BITS, 10, PHT index width; PHT depth = 2**IDX_BITS entries of 2 bits
GHR_BITS, 8, global history length; must satisfy GHR_BITS <= IDX_BITS and IDX_BITS+2 <= PC_BITS

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall_F  input  1  fetch stalled; no speculative GHR update this cycle
fetch_branch  input  LANES  lane i holds a conditional branch
fetch_pc  input  LANES*PC_BITS  PC of lane i, lane 0 in LSBs
pred_taken  output  LANES  lane i predicted taken (combinational)
pred_ghr  output  LANES*GHR_BITS  history used to index lane i, carried down pipe for update
upd_valid  input  1  resolved conditional branch from EX
upd_pc  input  PC_BITS  PC of resolved branch
upd_ghr  input  GHR_BITS  pred_ghr captured at that branch's fetch
upd_taken  input  1  actual outcome
upd_mispredict  input  1  prediction was wrong; repair GHR
ghr_out  output  GHR_BITS  current committed/speculative GHR (debug)

Behaviour:
- Reset (rst=1 at edge): every PHT entry <= 2'b01 (weakly not-taken); GHR <= 0. Outputs then: pred_taken=0 for all lanes; pred_ghr lane 0 = 0; ghr_out=0. Reset overrides any same-cycle update or fetch.
- Index: idx_i = fetch_pc_i[IDX_BITS+1:2] XOR zero-extended h_i, with history in the low bits.
- Prediction: pred_taken_i = fetch_branch_i & PHT[idx_i][1] & ~kill_i. Pure combinational read; zero-cycle latency.
- Intra-group history chaining:
  - h_0 = GHR.
  - h_{i+1} = fetch_branch_i ? {h_i[GHR_BITS-2:0], pred_taken_i} : h_i.
  - pred_ghr_i = h_i.
- Group cut: kill_i = 1 if any lane j<i has pred_taken_j=1. Killed lanes predict 0 and are not shifted into history.
- Speculative GHR update at edge:
  - Applies when stall_F=0 and upd_mispredict is not asserted with upd_valid.
  - GHR <= h_LANES, i.e. history after the last unkilled lane.
  - Non-branch lanes leave history unchanged.
- Repair at edge: upd_valid & upd_mispredict sets GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}. Repair has priority over the same-cycle speculative update and ignores stall_F.
- Training at edge: upd_valid=1 updates PHT[upd_pc[IDX_BITS+1:2] XOR upd_ghr] as a saturating counter.
  - upd_taken=1: increment, saturating at 3.
  - upd_taken=0: decrement, saturating at 0.
- Same-cycle read/write of the same PHT index: fetch reads the pre-update value unless the bypass feature is compiled in.
- upd_mispredict without upd_valid is ignored.
- GHR_BITS=1 is legal; shift degenerates to GHR <= newest outcome.
- Mid-operation reset discards all in-flight history; later updates carrying stale upd_ghr values are processed normally.

Optional Feature:
- Macro: GSHARE_UPD_BYPASS_EN.
- Defined: when upd_valid=1 and idx_i equals the update index in the same cycle, lane i's prediction uses the post-update counter value.
- Not defined: lane i uses the stored (pre-update) value.
- GHR behaviour is identical either way.

Test Plan:
- Reset, then fetch_branch=2'b01, fetch_pc lane0=14'h0040 -> pred_taken=2'b00, pred_ghr lane0=0. After edge, ghr_out=8'h00 (a predicted-not-taken branch shifts in 0).
- Train idx 0x010 (pc 14'h0040, ghr 0) with upd_taken=1 twice -> counter 01->10->11; next fetch of pc 0x0040 with GHR=0 -> pred_taken[0]=1.
- Two-lane group, both branches, lane0 predicted taken -> lane1 killed: pred_taken=2'b01. pred_ghr lane1 = {GHR[6:0],1}. ghr_out after edge = {old[6:0],1}, one shift only.
- With ghr_out=8'hA5, assert upd_valid=1, upd_mispredict=1, upd_ghr=8'h3C, upd_taken=0, together with an unstalled fetch -> ghr_out next cycle = 8'h78. The fetch's speculative shift is discarded.
- stall_F=1 with lane branches present -> ghr_out unchanged. A counter at 3 trained taken stays 3; a counter at 0 trained not-taken stays 0.
- Same-cycle fetch and training to one index at counter 01, upd_taken=1 -> pred_taken=0 without GSHARE_UPD_BYPASS_EN, 1 with it.
